// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared instruction/data memory port
// Define MEM_ARB_RR_EN for round-robin selection; the default build is fixed priority (m0 wins).
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
   logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic              busy_q, busy_d;
   logic              pick_m1;

`ifdef MEM_ARB_RR_EN
   logic              last_m1_q, last_m1_d;
   // On contention the requester that was not granted last wins.
   assign pick_m1 = m1_req && (!m0_req || !last_m1_q);
`else
   assign pick_m1 = !m0_req;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      m0_gnt_d    = 1'b0;
      m1_gnt_d    = 1'b0;
      m0_rvalid_d = 1'b0;
      m1_rvalid_d = 1'b0;
      m0_rdata_d  = m0_rdata_q;
      m1_rdata_d  = m1_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_m1_d   = last_m1_q;
`endif
      case (state_q)
         IDLE: begin
            // The mem_* output flops double as the captured command.
            if (m0_req || m1_req) begin
               owner_d     = pick_m1;
               mem_en_d    = 1'b1;
               mem_we_d    = pick_m1 ? m1_we    : m0_we;
               mem_addr_d  = pick_m1 ? m1_addr  : m0_addr;
               mem_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
               m0_gnt_d    = !pick_m1;
               m1_gnt_d    = pick_m1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
`ifdef MEM_ARB_RR_EN
            last_m1_d = owner_q;
`endif
            if (mem_we_q) begin
               state_d = IDLE;
            end else begin
               cnt_d   = 3'(MEM_LAT - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               if (owner_q) begin
                  m1_rdata_d  = mem_rdata;
                  m1_rvalid_d = 1'b1;
               end else begin
                  m0_rdata_d  = mem_rdata;
                  m0_rvalid_d = 1'b1;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         cnt_q       <= 3'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_m1_q   <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         m0_gnt_q    <= m0_gnt_d;
         m1_gnt_q    <= m1_gnt_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
         last_m1_q   <= last_m1_d;
`endif
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign m0_gnt    = m0_gnt_q;
   assign m1_gnt    = m1_gnt_q;
   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at MEM_LAT 1 and 3
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

   logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we, a_busy;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we, b_busy;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_lat3 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] addr);
      return (addr == 32'h10) ? 32'hDEADBEEF : {16'hC0DE, addr[15:0]};
   endfunction

   // Memory models: read data is valid only in the cycle exactly MEM_LAT after mem_en.
   logic [31:0] a_p0 = '0, b_p0 = '0, b_p1 = '0, b_p2 = '0;
   always @(posedge clk) begin
      a_p0 <= (a_mem_en && !a_mem_we) ? mem_val(a_mem_addr) : 32'h0;
      b_p0 <= (b_mem_en && !b_mem_we) ? mem_val(b_mem_addr) : 32'h0;
      b_p1 <= b_p0;
      b_p2 <= b_p1;
   end
   assign a_mem_rdata = a_p0;
   assign b_mem_rdata = b_p2;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      m0_req = 1'b0;
      m1_req = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   int g0, g1, idx, waits, rv;
   logic [3:0] order;

   initial begin
      // Reset state
      #1;
      do_reset();
      check("rst_mem_en", a_mem_en, 0);
      check("rst_busy", a_busy, 0);
      check("rst_gnt", {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid}, 0);
      check("rst_rdata", {a_m0_rdata, a_m1_rdata}, 0);
      check("rst_bus", {a_mem_we, a_mem_addr, a_mem_wdata}, 0);

      // 1: m0 read 0x10, MEM_LAT=1
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
      step();
      check("t1_gnt", {a_m0_gnt, a_m1_gnt}, 2'b10);
      check("t1_issue", {a_mem_en, a_mem_we}, 2'b10);
      check("t1_addr", a_mem_addr, 32'h10);
      m0_req = 1'b0;
      step();
      check("t1_c2_rvalid", a_m0_rvalid, 0);
      check("t1_c2_mem_en", a_mem_en, 0);
      step();
      check("t1_rvalid", a_m0_rvalid, 1);
      check("t1_rdata", a_m0_rdata, 32'hDEADBEEF);
      check("t1_c3_busy", a_busy, 1);
      step();
      check("t1_busy_fall", {a_busy, a_m0_rvalid}, 0);

      // 2: m1 write 0x20 <- 0x1234
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234;
      step();
      check("t2_gnt", {a_m0_gnt, a_m1_gnt}, 2'b01);
      check("t2_issue", {a_mem_en, a_mem_we}, 2'b11);
      check("t2_addr", a_mem_addr, 32'h20);
      check("t2_wdata", a_mem_wdata, 32'h1234);
      m1_req = 1'b0;
      rv = 0;
      step();
      check("t2_busy", {a_busy, a_mem_en}, 0);
      for (int i = 0; i < 4; i++) begin
         if (a_m1_rvalid) rv++;
         step();
      end
      check("t2_no_rvalid", rv, 0);

      // 3: both requesters reading, held high for 4 accesses
      do_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
      g0 = 0; g1 = 0; idx = 0; order = '0;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (a_m0_gnt) g0++;
         if (a_m1_gnt) g1++;
         if ((a_m0_gnt || a_m1_gnt) && idx < 4) begin
            order[idx] = a_m1_gnt;
            idx++;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
`ifdef MEM_ARB_RR_EN
      check("t3_m0_gnts", g0, 2);
      check("t3_m1_gnts", g1, 2);
      check("t3_order", order, 4'b1010);
`else
      check("t3_m0_gnts", g0, 4);
      check("t3_m1_gnts", g1, 0);
      check("t3_order", order, 4'b0000);
`endif

      // 4: MEM_LAT=3; preload m1_rdata, then m0 read 0x40
      do_reset();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h50;
      step();
      check("t4_m1_gnt", b_m1_gnt, 1);
      m1_req = 1'b0;
      step(4);
      check("t4_m1_rvalid", b_m1_rvalid, 1);
      check("t4_m1_rdata", b_m1_rdata, 32'hC0DE0050);
      step();
      check("t4_idle", b_busy, 0);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
      step();
      check("t4_gnt", {b_m0_gnt, b_mem_en, b_mem_addr}, {2'b11, 32'h40});
      m0_req = 1'b0;
      waits = 0;
      for (int c = 2; c <= 4; c++) begin
         step();
         if (b_busy && !b_m0_gnt && !b_m0_rvalid && !b_mem_en) waits++;
         check("t4_m1_rdata_hold", b_m1_rdata, 32'hC0DE0050);
      end
      check("t4_wait_cycles", waits, 3);
      step();
      check("t4_rvalid", {b_m0_rvalid, b_m1_rvalid}, 2'b10);
      check("t4_rdata", b_m0_rdata, 32'hC0DE0040);
      check("t4_m1_rdata_end", b_m1_rdata, 32'hC0DE0050);
      step();
      check("t4_busy_fall", b_busy, 0);

      // 5: reset during WAIT of an m1 read
      do_reset();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30;
      step();
      check("t5_gnt", a_m1_gnt, 1);
      m1_req = 1'b0;
      step();
      check("t5_in_wait", {a_busy, a_mem_en, a_m1_rvalid}, 3'b100);
      reset = 1'b1;
      step();
      check("t5_after_rst", {a_busy, a_mem_en, a_m1_rvalid, a_m1_gnt}, 0);
      check("t5_rdata_clr", a_m1_rdata, 0);
      reset = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h70; m0_wdata = 32'h55;
      step();
      check("t5_wr_gnt", {a_m0_gnt, a_mem_en, a_mem_we}, 3'b111);
      check("t5_wr_data", a_mem_wdata, 32'h55);
      check("t5_no_m1_rvalid", a_m1_rvalid, 0);
      m0_req = 1'b0;
      step();

      // 6: m1 req rises during an m0 read's WAIT
      do_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h60;
      step();
      check("t6_m0_gnt", a_m0_gnt, 1);
      m0_req = 1'b0;
      step();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h64;
      g1 = 0;
      step();
      if (a_m1_gnt) g1++;
      check("t6_m0_rvalid", a_m0_rvalid, 1);
      check("t6_m0_rdata", a_m0_rdata, 32'hC0DE0060);
      step();
      if (a_m1_gnt) g1++;
      check("t6_idle", a_busy, 0);
      check("t6_no_early_gnt", g1, 0);
      step();
      check("t6_m1_gnt", {a_m1_gnt, a_mem_addr}, {1'b1, 32'h64});
      m1_req = 1'b0;
      step(3);
      check("t6_m1_rdata", a_m1_rdata, 32'hC0DE0064);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters.
- Requester 0 is the multicycle core (fetch and load/store); requester 1 is the program loader/debug port.
- Sequences each access: capture, issue, wait out the fixed read latency, return data. Only one access is in flight at a time.
- Sits between the core's address mux and the memory macro.

Parameters:
- ADDR_W, 32, width of the address on both requesters and the memory.
- DATA_W, 32, width of the read/write data.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.

Ports:
clk  in  1  clock; everything updates on the rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  core request; held high with a stable command until m0_gnt
m0_we  in  1  core write (1) / read (0)
m0_addr  in  ADDR_W  core address
m0_wdata  in  DATA_W  core write data
m0_gnt  out  1  one-cycle pulse: core command issued to memory
m0_rvalid  out  1  one-cycle pulse: core read data valid
m0_rdata  out  DATA_W  core read data; held until the next m0 read response
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as the m0 ports, for the loader
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable; only meaningful with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0, including the rdata registers. State is IDLE. Latency counter is 0. RR pointer is "last = m1".
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner and register its we/addr/wdata and a 1-bit owner flag. Next state: ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr, mem_wdata driven from the captured registers.
  - The owner's gnt pulses this cycle.
  - Write: next state IDLE. Read: load the counter with MEM_LAT-1, next state WAIT.
- WAIT:
  - If counter==0, register mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise decrement the counter.
  - The capture happens on the edge at the end of cycle ISSUE+MEM_LAT.
- RESP (1 cycle): the owner's rvalid=1; the new rdata is visible. Next state IDLE.
- Latency from req sampled in IDLE:
  - Write: gnt in cycle +1; next request is accepted in cycle +2.
  - Read: gnt in cycle +1, rvalid in cycle +MEM_LAT+2, IDLE again in cycle +MEM_LAT+3.
- Outside ISSUE, mem_en=0 and the mem_* buses are 0.
- A req that is still high after its gnt is a new request. The requester must drop req in the cycle after gnt if it wants no further access.
- The non-winning req stays pending; it is not captured, and it is not granted until a later IDLE.
- req changes while the arbiter is not in IDLE are ignored. Only the IDLE-cycle sample matters.
- m0_rdata and m1_rdata are independent; a response to one never disturbs the other.
- Reset mid-operation (any state):
  - Abandon the access; no rvalid for it.
  - mem_en goes low in the cycle after reset is sampled.
  - Return to IDLE with the reset values above.
  - A write already issued in ISSUE is not undone.
- Counter width is 3 bits. MEM_LAT=1 means WAIT lasts exactly 1 cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- When defined: round-robin selection.
  - When both req are high in IDLE, grant the requester not granted last.
  - A single requester always wins.
  - The pointer updates in ISSUE.
- When not defined: fixed priority, m0 always wins. m1 can starve while m0 requests back-to-back. The pointer logic is absent.

Test Plan:
1. Reset, then m0 read addr 0x10 with MEM_LAT=1 and memory returning 0xDEADBEEF -> m0_gnt at cycle 1 with mem_en=1, mem_we=0, mem_addr=0x10; m0_rvalid at cycle 3 with m0_rdata=0xDEADBEEF; busy falls at cycle 4.
2. m1 write addr 0x20, data 0x1234 -> m1_gnt and mem_en=1, mem_we=1, mem_wdata=0x1234 at cycle 1; busy=0 at cycle 2; m1_rvalid never asserts.
3. m0 and m1 both reading, both held high for 4 accesses:
   - Without MEM_ARB_RR_EN: 4 m0_gnt, 0 m1_gnt.
   - With MEM_ARB_RR_EN: grants alternate m0, m1, m0, m1.
4. MEM_LAT=3, m0 read at 0x40 -> exactly 3 WAIT cycles; rvalid at cycle 5; m1_rdata unchanged throughout.
5. reset asserted during WAIT of an m1 read -> no m1_rvalid; all outputs 0 on the next cycle; a following m0 write is granted 1 cycle after req is sampled in IDLE.
6. m1 req rises during an m0 read's WAIT state -> m1 is not granted until after m0's RESP, then m1_gnt 1 cycle after IDLE.
